// File: rtl/cpu_pkg.sv
// Shared core definitions: word width, reset vector, break opcode and the
// fetch FSM state encoding.
package cpu_pkg;

    localparam int WORD_W = 32;

    localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0040_0000;
    localparam logic [WORD_W-1:0] BREAK_INSN       = 32'h0000_000D;

    typedef enum logic [1:0] {
        FS_IDLE    = 2'd0,
        FS_FETCH   = 2'd1,
        FS_DISCARD = 2'd2,
        FS_HOLD    = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/pc_register.sv
// Program counter flop with reset vector, sequential +4 advance and a
// redirect load that takes priority over the advance.
module pc_register
    import cpu_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [WORD_W-1:0] load_pc,
    input  logic              advance,
    output logic [WORD_W-1:0] pc,
    output logic [WORD_W-1:0] pc_plus4
);

    // Plain 32-bit add, so 32'hFFFF_FFFC rolls over to zero.
    assign pc_plus4 = pc + 32'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_pc;
        end else if (advance) begin
            pc <= pc_plus4;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, imem request/ack handshake and the instruction register.
// Optional FETCH_ALIGN_CHECK_EN turns misaligned redirects into a break fault.
//
// state   | meaning
// IDLE    | one cycle after reset before the first request
// FETCH   | request outstanding at pc
// DISCARD | redirected mid-request; waiting to drop the stale word
// HOLD    | ir valid, waiting for ir_ready or a redirect
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [WORD_W-1:0] imem_rdata,
    output logic [WORD_W-1:0] ir,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic [WORD_W-1:0] pc,
    output logic [WORD_W-1:0] pc_plus4,
    input  logic              redirect_valid,
    input  logic [WORD_W-1:0] redirect_pc
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic              fetch_exc
`endif
);

    fetch_state_t      state, state_nx;
    logic [WORD_W-1:0] pending_pc;
    logic [WORD_W-1:0] redir_tgt;
    logic [WORD_W-1:0] discard_tgt;
    logic [WORD_W-1:0] pc_load_val;
    logic              redir_bad;
    logic              discard_bad;
    logic              pc_load;
    logic              pc_adv;
    logic              ir_load;
    logic              pend_load;
    logic              take_exc;
    logic              exc_q;

    // A redirect arriving together with the DISCARD ack is newer than the pending target.
    assign discard_tgt = redirect_valid ? redir_tgt : pending_pc;

`ifdef FETCH_ALIGN_CHECK_EN
    assign redir_tgt   = redirect_pc;
    assign redir_bad   = (redirect_pc[1:0] != 2'b00);
    assign discard_bad = (discard_tgt[1:0] != 2'b00);
    assign fetch_exc   = exc_q;
`else
    assign redir_tgt   = redirect_pc & 32'hFFFF_FFFC;
    assign redir_bad   = 1'b0;
    assign discard_bad = 1'b0;
`endif

    assign imem_req  = (state == FS_FETCH) || (state == FS_DISCARD);
    assign imem_addr = pc;

    always_comb begin
        state_nx    = state;
        pc_load     = 1'b0;
        pc_adv      = 1'b0;
        pc_load_val = redir_tgt;
        ir_load     = 1'b0;
        pend_load   = 1'b0;
        take_exc    = 1'b0;
        case (state)
            FS_IDLE: begin
                state_nx = FS_FETCH;
                if (redirect_valid) begin
                    pc_load = 1'b1;
                    if (redir_bad) begin
                        take_exc = 1'b1;
                        state_nx = FS_HOLD;
                    end
                end
            end
            FS_FETCH: begin
                if (redirect_valid) begin
                    if (imem_ack) begin
                        pc_load = 1'b1;
                        if (redir_bad) begin
                            take_exc = 1'b1;
                            state_nx = FS_HOLD;
                        end
                    end else begin
                        pend_load = 1'b1;
                        state_nx  = FS_DISCARD;
                    end
                end else if (imem_ack) begin
                    ir_load  = 1'b1;
                    state_nx = FS_HOLD;
                end
            end
            FS_DISCARD: begin
                if (imem_ack) begin
                    pc_load     = 1'b1;
                    pc_load_val = discard_tgt;
                    if (discard_bad) begin
                        take_exc = 1'b1;
                        state_nx = FS_HOLD;
                    end else begin
                        state_nx = FS_FETCH;
                    end
                end else if (redirect_valid) begin
                    pend_load = 1'b1;
                end
            end
            FS_HOLD: begin
                // A faulted break waits for the handler's redirect, not ir_ready.
                if (redirect_valid) begin
                    pc_load = 1'b1;
                    if (redir_bad) begin
                        take_exc = 1'b1;
                    end else begin
                        state_nx = FS_FETCH;
                    end
                end else if (ir_ready && !exc_q) begin
                    pc_adv   = 1'b1;
                    state_nx = FS_FETCH;
                end
            end
            default: state_nx = FS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FS_IDLE;
            ir         <= '0;
            ir_valid   <= 1'b0;
            pending_pc <= RESET_PC;
            exc_q      <= 1'b0;
        end else begin
            state    <= state_nx;
            ir_valid <= (state_nx == FS_HOLD);
            if (ir_load) begin
                ir <= imem_rdata;
            end else if (take_exc) begin
                ir <= BREAK_INSN;
            end
            if (pend_load) begin
                pending_pc <= redir_tgt;
            end
            if (take_exc) begin
                exc_q <= 1'b1;
            end else if (redirect_valid) begin
                exc_q <= 1'b0;
            end
        end
    end

    pc_register #(
        .RESET_PC (RESET_PC)
    ) u_pc_register (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (pc_load),
        .load_pc  (pc_load_val),
        .advance  (pc_adv),
        .pc       (pc),
        .pc_plus4 (pc_plus4)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios then a random
// instruction stream checked against a program-order reference model.
module tb_instr_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] ir;
    logic        ir_valid;
    logic        ir_ready;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        fetch_exc;
`endif

    int          n_assert = 0;
    int          n_fail   = 0;
    int          mem_wait = 0;
    bit          busy;
    int          wait_left;
    logic [31:0] req_addr;
    logic [31:0] exp_pc;

    instr_fetch_unit #(
        .RESET_PC (RST_PC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .ir             (ir),
        .ir_valid       (ir_valid),
        .ir_ready       (ir_ready),
        .pc             (pc),
        .pc_plus4       (pc_plus4),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .fetch_exc      (fetch_exc)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0040_0000) return 32'h2008_0005;
        return {a[15:0], a[31:16]} ^ 32'hC3A5_96E1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Instruction memory: mem_wait wait cycles per request (-1 = random 0..3).
    initial begin
        imem_ack   = 1'b0;
        imem_rdata = '0;
        busy       = 1'b0;
        wait_left  = 0;
        forever begin
            @(negedge clk);
            imem_ack = 1'b0;
            if (rst_n && imem_req) begin
                check_bit("no_valid_during_req", ir_valid, 1'b0);
                if (!busy) begin
                    busy      = 1'b1;
                    req_addr  = imem_addr;
                    wait_left = (mem_wait < 0) ? int'($urandom_range(0, 3)) : mem_wait;
                end else begin
                    check("addr_stable", imem_addr, req_addr);
                end
                if (wait_left == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem_word(imem_addr);
                    busy       = 1'b0;
                end else begin
                    wait_left--;
                end
            end else begin
                busy = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge rst_n);
            imem_ack = 1'b0;
            busy     = 1'b0;
        end
    end

    task automatic wait_valid(input string tag);
        int k = 0;
        while (ir_valid !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check_bit({tag, "_valid_timeout"}, ir_valid, 1'b1);
    endtask

    task automatic wait_req(input string tag);
        int k = 0;
        while (imem_req !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check_bit({tag, "_req_timeout"}, imem_req, 1'b1);
    endtask

    task automatic pulse_ready();
        ir_ready = 1'b1;
        @(negedge clk);
        ir_ready = 1'b0;
    endtask

    task automatic redirect_to(input logic [31:0] tgt, input logic rdy);
        ir_ready       = rdy;
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        @(negedge clk);
        ir_ready       = 1'b0;
        redirect_valid = 1'b0;
    endtask

    initial begin
        rst_n          = 1'b0;
        ir_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        // Reset values and zero-wait first fetch
        mem_wait = 0;
        repeat (2) @(negedge clk);
        check_bit("rst_req", imem_req, 1'b0);
        check_bit("rst_valid", ir_valid, 1'b0);
        check("rst_ir", ir, 32'h0);
        check("rst_pc", pc, RST_PC);
        check("rst_pc_plus4", pc_plus4, 32'h0040_0004);
        check("rst_addr", imem_addr, RST_PC);
`ifdef FETCH_ALIGN_CHECK_EN
        check_bit("rst_exc", fetch_exc, 1'b0);
`endif
        rst_n = 1'b1;
        wait_req("zw");
        check("zw_addr", imem_addr, RST_PC);
        @(negedge clk);
        check_bit("zw_valid_1cyc", ir_valid, 1'b1);
        check("zw_ir", ir, 32'h2008_0005);
        check_bit("zw_req_low", imem_req, 1'b0);

        // Three-wait memory, ir held while ir_ready low
        mem_wait = 3;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_req("w3");
        for (int i = 0; i < 4; i++) begin
            check_bit("w3_req_held", imem_req, 1'b1);
            check("w3_addr_held", imem_addr, RST_PC);
            check_bit("w3_not_valid", ir_valid, 1'b0);
            @(negedge clk);
        end
        check_bit("w3_valid", ir_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("w3_ir_stable", ir, 32'h2008_0005);
            check_bit("w3_valid_stable", ir_valid, 1'b1);
            check_bit("w3_no_req", imem_req, 1'b0);
            @(negedge clk);
        end
        mem_wait = 0;
        pulse_ready();
        check_bit("seq_req", imem_req, 1'b1);
        check("seq_addr", imem_addr, 32'h0040_0004);
        wait_valid("seq");
        check("seq_ir", ir, mem_word(32'h0040_0004));
        check("seq_pc", pc, 32'h0040_0004);

        // Redirect beats sequential advance in HOLD
        redirect_to(32'h0040_0100, 1'b1);
        check_bit("hold_redir_req", imem_req, 1'b1);
        check("hold_redir_addr", imem_addr, 32'h0040_0100);
        wait_valid("hold_redir");
        check("hold_redir_ir", ir, mem_word(32'h0040_0100));
        check("hold_redir_pc_plus4", pc_plus4, 32'h0040_0104);

        // Redirect during a 2-wait fetch: stale word dropped
        mem_wait = 2;
        pulse_ready();
        check("disc_first_addr", imem_addr, 32'h0040_0104);
        redirect_to(32'h0040_0200, 1'b0);
        check_bit("disc_req", imem_req, 1'b1);
        check("disc_old_addr", imem_addr, 32'h0040_0104);
        check_bit("disc_no_valid", ir_valid, 1'b0);
        @(negedge clk);
        check("disc_old_addr2", imem_addr, 32'h0040_0104);
        @(negedge clk);
        check_bit("disc_dropped_valid", ir_valid, 1'b0);
        check_bit("disc_refetch_req", imem_req, 1'b1);
        check("disc_refetch_addr", imem_addr, 32'h0040_0200);
        wait_valid("disc");
        check("disc_ir", ir, mem_word(32'h0040_0200));
        check("disc_pc", pc, 32'h0040_0200);

        // PC wrap-around
        mem_wait = 0;
        redirect_to(32'hFFFF_FFFC, 1'b0);
        wait_valid("wrap");
        check("wrap_pc", pc, 32'hFFFF_FFFC);
        check("wrap_pc_plus4", pc_plus4, 32'h0);
        check("wrap_ir", ir, mem_word(32'hFFFF_FFFC));
        mem_wait = 3;
        pulse_ready();
        check_bit("wrap_req", imem_req, 1'b1);
        check("wrap_addr", imem_addr, 32'h0);

        // Reset mid-fetch
        #2 rst_n = 1'b0;
        #1;
        check_bit("midrst_req", imem_req, 1'b0);
        check_bit("midrst_valid", ir_valid, 1'b0);
        check("midrst_pc", pc, RST_PC);
        @(negedge clk);
        mem_wait = 0;
        rst_n = 1'b1;
        wait_req("midrst");
        check("midrst_refetch_addr", imem_addr, RST_PC);
        wait_valid("midrst");
        check("midrst_ir", ir, 32'h2008_0005);
        exp_pc = RST_PC;

`ifdef FETCH_ALIGN_CHECK_EN
        redirect_to(32'h0040_0102, 1'b0);
        check_bit("align_no_req", imem_req, 1'b0);
        check("align_ir", ir, 32'h0000_000D);
        check_bit("align_valid", ir_valid, 1'b1);
        check_bit("align_exc", fetch_exc, 1'b1);
        check("align_pc", pc, 32'h0040_0102);
        pulse_ready();
        check_bit("align_ready_ignored", imem_req, 1'b0);
        redirect_to(32'h0040_0300, 1'b0);
        check_bit("align_exc_clear", fetch_exc, 1'b0);
        check("align_clear_addr", imem_addr, 32'h0040_0300);
        wait_valid("align");
        exp_pc = 32'h0040_0300;
`endif

        // Random stream against the program-order model
        mem_wait = -1;
        for (int it = 0; it < 60; it++) begin
            logic [31:0] tgt;
            int          kind;
            check("rnd_ir", ir, mem_word(exp_pc));
            check("rnd_pc", pc, exp_pc);
            check("rnd_pc_plus4", pc_plus4, exp_pc + 32'd4);
`ifdef FETCH_ALIGN_CHECK_EN
            check_bit("rnd_exc", fetch_exc, 1'b0);
`endif
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                check("rnd_ir_hold", ir, mem_word(exp_pc));
                check_bit("rnd_valid_hold", ir_valid, 1'b1);
            end
            tgt = $urandom;
`ifdef FETCH_ALIGN_CHECK_EN
            tgt = tgt & 32'hFFFF_FFFC;
`endif
            kind = int'($urandom_range(0, 3));
            if (kind < 2) begin
                pulse_ready();
                exp_pc = exp_pc + 32'd4;
            end else if (kind == 2) begin
                redirect_to(tgt, 1'($urandom_range(0, 1)));
                exp_pc = tgt & 32'hFFFF_FFFC;
            end else begin
                pulse_ready();
                repeat ($urandom_range(0, 2)) @(negedge clk);
                redirect_to(tgt, 1'b0);
                exp_pc = tgt & 32'hFFFF_FFFC;
            end
            wait_valid("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
